// File: rtl/trace_capture_fifo.sv
// Retired-instruction trace capture FIFO: tags each commit with a sequence number,
// buffers it for a valid/ready sink and drops (with counting) when the FIFO is full.
module trace_capture_fifo #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     flush_i,
    input  logic                     trace_valid_i,
    input  logic [31:0]              trace_insn_i,
    input  logic [31:0]              trace_addr_i,
    input  logic                     trace_exception_i,
    input  logic [4:0]               trace_ecause_i,
    input  logic                     trace_interrupt_i,
    input  logic [31:0]              trace_tval_i,
    output logic                     rec_valid_o,
    input  logic                     rec_ready_i,
    output logic [31:0]              rec_seq_o,
    output logic                     rec_drop_o,
    output logic [31:0]              rec_insn_o,
    output logic [31:0]              rec_addr_o,
    output logic                     rec_exc_o,
    output logic [4:0]               rec_ecause_o,
    output logic                     rec_int_o,
    output logic [31:0]              rec_tval_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0] seq;
        logic        drop;
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic [4:0]  ecause;
        logic        intr;
        logic [31:0] tval;
    } rec_t;

    rec_t              mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [31:0]       seq_q, seq_d;
    logic              drop_pending_q, drop_pending_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [PW-1:0] level;
    logic          empty, full, commit, push, pop, drop;
    rec_t          wr_rec, head;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign empty  = (level == '0);
    assign full   = (level == PW'(DEPTH));
    assign commit = trace_valid_i & enable_i;
    // Flush wins over both sides of the handshake.
    assign pop    = ~empty & rec_ready_i & ~flush_i;
    assign push   = commit & ~flush_i & (~full | pop);
    assign drop   = commit & ~push;

    always_comb begin
        wr_rec        = '0;
        wr_rec.seq    = seq_q;
        wr_rec.drop   = drop_pending_q;
        wr_rec.insn   = trace_insn_i;
        wr_rec.addr   = trace_addr_i;
        wr_rec.exc    = trace_exception_i;
        wr_rec.ecause = trace_ecause_i;
        wr_rec.intr   = trace_interrupt_i;
        wr_rec.tval   = trace_tval_i;
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        drop_pending_d = drop_pending_q;
        seq_d          = commit ? seq_q + 32'd1 : seq_q;
        drop_cnt_d     = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
        if (flush_i) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            drop_pending_d = drop_pending_q | ~empty | drop;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push)      drop_pending_d = 1'b0;
            else if (drop) drop_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            seq_q          <= '0;
            drop_pending_q <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            seq_q          <= seq_d;
            drop_pending_q <= drop_pending_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
    end

    // Head fields are forced to zero while empty so stale entries never leak out.
    assign head         = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign rec_valid_o  = ~empty;
    assign rec_seq_o    = head.seq;
    assign rec_drop_o   = head.drop;
    assign rec_insn_o   = head.insn;
    assign rec_addr_o   = head.addr;
    assign rec_exc_o    = head.exc;
    assign rec_ecause_o = head.ecause;
    assign rec_int_o    = head.intr;
    assign rec_tval_o   = head.tval;
    assign level_o      = level;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: doc/trace_capture_fifo.md
Name: trace_capture_fifo

Overview:
- Sits directly downstream of the VeeR EL2 instruction trace port (trace_rv_i_*) inside the guineveer SoC.
- Captures every retired-instruction record into a small FIFO and tags it with a commit sequence number.
- Presents the records on a valid/ready stream to a trace sink (trace-to-memory writer or simulation trace dump).
- The core cannot be stalled, so overflow is handled by dropping records, counting them and flagging the loss.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  capture enable; when low, trace_valid_i is ignored.
- flush_i  in  1  single-cycle pulse; empties the FIFO.
- trace_valid_i  in  1  retired-instruction strobe from the core.
- trace_insn_i  in  32  instruction opcode.
- trace_addr_i  in  32  instruction PC.
- trace_exception_i  in  1  exception flag.
- trace_ecause_i  in  5  exception cause.
- trace_interrupt_i  in  1  interrupt flag.
- trace_tval_i  in  32  trap value.
- rec_valid_o  out  1  head record valid.
- rec_ready_i  in  1  sink accepts the head record.
- rec_seq_o  out  32  commit sequence number of the head record.
- rec_drop_o  out  1  one or more records were dropped immediately before this record.
- rec_insn_o  out  32  head opcode.
- rec_addr_o  out  32  head PC.
- rec_exc_o  out  1  head exception flag.
- rec_ecause_o  out  5  head exception cause.
- rec_int_o  out  1  head interrupt flag.
- rec_tval_o  out  32  head trap value.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  out  DROP_W  total dropped records, saturating.

Behaviour:
- Reset (rst_i high at a clk_i edge): all outputs, pointers, seq_q, drop_pending_q and drop_cnt_o go to 0; no stored record survives. Reset in mid-stream discards all queued data.
- Capture: a commit occurs on any cycle with trace_valid_i && enable_i. Each commit assigns seq_q to the record and then increments seq_q by 1, wrapping modulo 2^32. Dropped commits also consume a sequence number, so gaps in the sink's sequence are visible.
- Push: a commit is pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle. The pushed entry stores rec_drop = drop_pending_q, and drop_pending_q then clears.
- Drop: a commit that cannot be pushed is discarded. drop_pending_q is set to 1, and drop_cnt_o increments, saturating at all-ones.
- Pop: a record is popped when rec_valid_o && rec_ready_i. Outputs rec_* reflect the head entry combinationally from storage. rec_* are don't-care when rec_valid_o is 0; the bench checks them only with rec_valid_o high.
- Latency: a record pushed at edge N appears on rec_valid_o after edge N; there is no bypass into an empty FIFO.
- Handshake: once rec_valid_o is high, it and the rec_* fields stay stable until popped. The only exceptions are flush and reset.
- Simultaneous push and pop on a non-empty FIFO leaves level_o unchanged. Push on an empty FIFO with rec_ready_i high does not pop in the same cycle.
- Flush: flush_i has priority over push and pop in the same cycle. It empties the FIFO (level_o becomes 0, rec_valid_o becomes 0 next cycle).
  - A commit arriving in the flush cycle is counted as dropped.
  - Flush sets drop_pending_q to 1 if the FIFO held any entry or a commit was dropped in that cycle.
  - Flush does not reset seq_q or drop_cnt_o.
- enable_i low: no commits, seq_q holds, and the FIFO still drains to the sink.
- Pointer width is $clog2(DEPTH)+1, with a wrap bit used for the full/empty distinction. Full is level_o == DEPTH.

Test Plan:
- Reset, then 3 commits with PC 0x80000000/04/08, rec_ready_i=1 → records emerge in order with seq 0,1,2, rec_drop_o=0, drop_cnt_o=0, level_o returns to 0.
- rec_ready_i=0, DEPTH+3=19 consecutive commits → level_o=16 and drop_cnt_o=3. Then with ready=1, the 16 records have seq 0..15. A 20th commit gives seq 19 with rec_drop_o=1.
- FIFO full (16), commit and pop in the same cycle → level_o stays 16, drop_cnt_o unchanged, new record stored with the next seq.
- 5 records queued, flush_i pulsed together with a commit → level_o=0 and drop_cnt_o=1 next cycle. The next commit has seq 6 with rec_drop_o=1.
- enable_i=0 with 4 trace_valid_i pulses, then enable_i=1 with 1 commit → only 1 record, carrying seq equal to the pre-disable value.
- rst_i asserted with 7 records queued and drop_cnt_o=2 → next cycle all outputs 0; a following commit gets seq 0 with rec_drop_o=0.
- Force drop_cnt_o to 0xFFFF (DROP_W=16), then cause 2 drops → drop_cnt_o stays 0xFFFF.
